// File: rtl/nts_ip_tx_header.sv
// Transmit-side Ethernet + IPv4/IPv6 + UDP header builder for NTS responses.
// The addressing and length fields are captured when a header starts. For
// IPv4 the header checksum is then summed over five cycles and folded in one
// more. The header is streamed as big-endian 64-bit words, with byte 0 in
// bits [63:56], over a valid/ready handshake.
module nts_ip_tx_header #(
    parameter logic [7:0]  IP4_TTL        = 8'd64,
    parameter logic [7:0]  IP6_HOP_LIMIT  = 8'd64,
    parameter logic [15:0] IP4_FLAGS_FRAG = 16'h4000
) (
    input  logic         i_clk,
    input  logic         i_areset,
    input  logic         i_clear,
    input  logic         i_start,
    input  logic         i_ipv6,
    input  logic [47:0]  i_dst_mac,
    input  logic [47:0]  i_src_mac,
    input  logic [31:0]  i_src_ip4,
    input  logic [31:0]  i_dst_ip4,
    input  logic [127:0] i_src_ip6,
    input  logic [127:0] i_dst_ip6,
    input  logic [15:0]  i_src_port,
    input  logic [15:0]  i_dst_port,
    input  logic [15:0]  i_udp_payload_length,
    input  logic [15:0]  i_udp_checksum,
    input  logic         i_ready,
    output logic         o_busy,
    output logic         o_error,
    output logic         o_valid,
    output logic [63:0]  o_data,
    output logic         o_last,
    output logic [7:0]   o_last_word_data_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CSUM = 2'd1,
        ST_FOLD = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    // Fold the 20-bit accumulator into 16 bits twice and take the one's complement.
    function automatic logic [15:0] fold_csum(input logic [19:0] acc);
        logic [16:0] s1;
        logic [16:0] s2;
        s1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
        return ~s2[15:0];
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    word_q, word_d;
    logic [2:0]    csum_cnt_q, csum_cnt_d;
    logic [19:0]   acc_q, acc_d;
    logic [15:0]   csum_q, csum_d;
    logic [15:0]   id_q, id_d;
    logic          ipv6_q, ipv6_d;
    logic [47:0]   dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
    logic [31:0]   src_ip4_q, src_ip4_d, dst_ip4_q, dst_ip4_d;
    logic [127:0]  src_ip6_q, src_ip6_d, dst_ip6_q, dst_ip6_d;
    logic [15:0]   src_port_q, src_port_d, dst_port_q, dst_port_d;
    logic [15:0]   tot_len_q, tot_len_d, udp_len_q, udp_len_d;
    logic [15:0]   udp_csum_q, udp_csum_d;
    logic          valid_q, valid_d, last_q, last_d, busy_q, busy_d, error_q, error_d;
    logic [63:0]   data_q, data_d;
    logic [7:0]    mask_q, mask_d;

    logic [2:0]    word_idx_s;
    logic [2:0]    last_idx_s;
    logic [63:0]   word_s;
    logic [15:0]   hw_a_s, hw_b_s;
    logic          overflow_s;

    // Select the header word that will be presented next, from the latched fields.
    always_comb begin
        word_idx_s = (state_q == ST_EMIT) ? (word_q + 3'd1) : 3'd0;
        last_idx_s = ipv6_q ? 3'd7 : 3'd5;
        word_s     = 64'd0;
        if (ipv6_q) begin
            case (word_idx_s)
                3'd0:    word_s = {dst_mac_q, src_mac_q[47:32]};
                3'd1:    word_s = {src_mac_q[31:0], 16'h86DD, 16'h6000};
                3'd2:    word_s = {16'h0000, udp_len_q, 8'h11, IP6_HOP_LIMIT, src_ip6_q[127:112]};
                3'd3:    word_s = src_ip6_q[111:48];
                3'd4:    word_s = {src_ip6_q[47:0], dst_ip6_q[127:112]};
                3'd5:    word_s = dst_ip6_q[111:48];
                3'd6:    word_s = {dst_ip6_q[47:0], src_port_q};
                3'd7:    word_s = {dst_port_q, udp_len_q, udp_csum_q, 16'h0000};
                default: word_s = 64'd0;
            endcase
        end else begin
            case (word_idx_s)
                3'd0:    word_s = {dst_mac_q, src_mac_q[47:32]};
                3'd1:    word_s = {src_mac_q[31:0], 16'h0800, 16'h4500};
                3'd2:    word_s = {tot_len_q, id_q, IP4_FLAGS_FRAG, IP4_TTL, 8'h11};
                3'd3:    word_s = {csum_q, src_ip4_q, dst_ip4_q[31:16]};
                3'd4:    word_s = {dst_ip4_q[15:0], src_port_q, dst_port_q, udp_len_q};
                3'd5:    word_s = {udp_csum_q, 48'd0};
                default: word_s = 64'd0;
            endcase
        end
    end

    // Pick the pair of IPv4 header halfwords summed in the current checksum cycle.
    always_comb begin
        case (csum_cnt_q)
            3'd0:    begin hw_a_s = 16'h4500;               hw_b_s = tot_len_q;          end
            3'd1:    begin hw_a_s = id_q;                   hw_b_s = IP4_FLAGS_FRAG;     end
            3'd2:    begin hw_a_s = {IP4_TTL, 8'h11};       hw_b_s = src_ip4_q[31:16];   end
            3'd3:    begin hw_a_s = src_ip4_q[15:0];        hw_b_s = dst_ip4_q[31:16];   end
            3'd4:    begin hw_a_s = dst_ip4_q[15:0];        hw_b_s = 16'h0000;           end
            default: begin hw_a_s = 16'h0000;               hw_b_s = 16'h0000;           end
        endcase
    end

    // Reject payloads that would overflow the 16-bit IP/UDP length fields.
    always_comb begin
        if (i_ipv6) begin
            overflow_s = (i_udp_payload_length > 16'd65527);
        end else begin
            overflow_s = (i_udp_payload_length > 16'd65507);
        end
    end

    // Next-state logic: the start/latch, checksum, fold and emit sequencing.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        csum_cnt_d = csum_cnt_q;
        acc_d      = acc_q;
        csum_d     = csum_q;
        id_d       = id_q;
        ipv6_d     = ipv6_q;
        dst_mac_d  = dst_mac_q;
        src_mac_d  = src_mac_q;
        src_ip4_d  = src_ip4_q;
        dst_ip4_d  = dst_ip4_q;
        src_ip6_d  = src_ip6_q;
        dst_ip6_d  = dst_ip6_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        tot_len_d  = tot_len_q;
        udp_len_d  = udp_len_q;
        udp_csum_d = udp_csum_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        mask_d     = mask_q;
        error_d    = 1'b0;

        if (i_clear) begin
            // Abort: the ID counter is deliberately left untouched.
            state_d    = ST_IDLE;
            word_d     = 3'd0;
            csum_cnt_d = 3'd0;
            acc_d      = 20'd0;
            valid_d    = 1'b0;
            data_d     = 64'd0;
            last_d     = 1'b0;
            mask_d     = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        ipv6_d     = i_ipv6;
                        dst_mac_d  = i_dst_mac;
                        src_mac_d  = i_src_mac;
                        src_ip4_d  = i_src_ip4;
                        dst_ip4_d  = i_dst_ip4;
                        src_ip6_d  = i_src_ip6;
                        dst_ip6_d  = i_dst_ip6;
                        src_port_d = i_src_port;
                        dst_port_d = i_dst_port;
                        tot_len_d  = i_udp_payload_length + 16'd28;
                        udp_len_d  = i_udp_payload_length + 16'd8;
                        udp_csum_d = i_udp_checksum;
                        word_d     = 3'd0;
                        csum_cnt_d = 3'd0;
                        acc_d      = 20'd0;
                        if (overflow_s) begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end else if (i_ipv6) begin
                            // No checksum for IPv6: word 0 goes out on the next cycle.
                            state_d = ST_EMIT;
                            valid_d = 1'b1;
                            data_d  = {i_dst_mac, i_src_mac[47:32]};
                            last_d  = 1'b0;
                            mask_d  = 8'hFF;
                        end else begin
                            state_d = ST_CSUM;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CSUM: begin
                    acc_d = acc_q + {4'd0, hw_a_s} + {4'd0, hw_b_s};
                    if (csum_cnt_q == 3'd4) begin
                        csum_cnt_d = 3'd0;
                        state_d    = ST_FOLD;
                    end else begin
                        csum_cnt_d = csum_cnt_q + 3'd1;
                    end
                end
                ST_FOLD: begin
                    csum_d  = fold_csum(acc_q);
                    state_d = ST_EMIT;
                    word_d  = 3'd0;
                    valid_d = 1'b1;
                    data_d  = word_s;
                    last_d  = 1'b0;
                    mask_d  = 8'hFF;
                end
                ST_EMIT: begin
                    if (valid_q && i_ready) begin
                        if (last_q) begin
                            state_d = ST_IDLE;
                            word_d  = 3'd0;
                            valid_d = 1'b0;
                            data_d  = 64'd0;
                            last_d  = 1'b0;
                            mask_d  = 8'd0;
                            if (!ipv6_q) begin
                                id_d = id_q + 16'd1;
                            end else begin
                                id_d = id_q;
                            end
                        end else begin
                            word_d = word_idx_s;
                            data_d = word_s;
                            if (word_idx_s == last_idx_s) begin
                                last_d = 1'b1;
                                mask_d = ipv6_q ? 8'hFC : 8'hC0;
                            end else begin
                                last_d = 1'b0;
                                mask_d = 8'hFF;
                            end
                        end
                    end else begin
                        // Backpressure: hold the presented word.
                        state_d = ST_EMIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q    <= ST_IDLE;
            word_q     <= 3'd0;
            csum_cnt_q <= 3'd0;
            acc_q      <= 20'd0;
            csum_q     <= 16'd0;
            id_q       <= 16'd0;
            ipv6_q     <= 1'b0;
            dst_mac_q  <= 48'd0;
            src_mac_q  <= 48'd0;
            src_ip4_q  <= 32'd0;
            dst_ip4_q  <= 32'd0;
            src_ip6_q  <= 128'd0;
            dst_ip6_q  <= 128'd0;
            src_port_q <= 16'd0;
            dst_port_q <= 16'd0;
            tot_len_q  <= 16'd0;
            udp_len_q  <= 16'd0;
            udp_csum_q <= 16'd0;
            valid_q    <= 1'b0;
            data_q     <= 64'd0;
            last_q     <= 1'b0;
            mask_q     <= 8'd0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            csum_cnt_q <= csum_cnt_d;
            acc_q      <= acc_d;
            csum_q     <= csum_d;
            id_q       <= id_d;
            ipv6_q     <= ipv6_d;
            dst_mac_q  <= dst_mac_d;
            src_mac_q  <= src_mac_d;
            src_ip4_q  <= src_ip4_d;
            dst_ip4_q  <= dst_ip4_d;
            src_ip6_q  <= src_ip6_d;
            dst_ip6_q  <= dst_ip6_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
            tot_len_q  <= tot_len_d;
            udp_len_q  <= udp_len_d;
            udp_csum_q <= udp_csum_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign o_busy                 = busy_q;
    assign o_error                = error_q;
    assign o_valid                = valid_q;
    assign o_data                 = data_q;
    assign o_last                 = last_q;
    assign o_last_word_data_valid = mask_q;

endmodule

// File: tb/tb_nts_ip_tx_header.sv
// Directed, table-driven bench for nts_ip_tx_header.
module tb_nts_ip_tx_header;

    logic         clk = 1'b0;
    logic         i_areset, i_clear, i_start, i_ipv6, i_ready;
    logic [47:0]  i_dst_mac, i_src_mac;
    logic [31:0]  i_src_ip4, i_dst_ip4;
    logic [127:0] i_src_ip6, i_dst_ip6;
    logic [15:0]  i_src_port, i_dst_port, i_udp_payload_length, i_udp_checksum;
    logic         o_busy, o_error, o_valid, o_last;
    logic [63:0]  o_data;
    logic [7:0]   o_last_word_data_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [47:0] DMAC  = 48'h0011_2233_4455;
    localparam logic [47:0] SMAC  = 48'h6677_8899_AABB;
    localparam logic [15:0] SPORT = 16'h007B;
    localparam logic [15:0] DPORT = 16'h116C;

    typedef struct {
        logic              ipv6;
        logic [31:0]       src4;
        logic [31:0]       dst4;
        logic [127:0]      src6;
        logic [127:0]      dst6;
        logic [15:0]       payload;
        logic [15:0]       ucsum;
        logic [7:0][63:0]  w;
    } vec_t;

    vec_t tbl [3];

    nts_ip_tx_header dut (
        .i_clk(clk), .i_areset(i_areset), .i_clear(i_clear), .i_start(i_start),
        .i_ipv6(i_ipv6), .i_dst_mac(i_dst_mac), .i_src_mac(i_src_mac),
        .i_src_ip4(i_src_ip4), .i_dst_ip4(i_dst_ip4),
        .i_src_ip6(i_src_ip6), .i_dst_ip6(i_dst_ip6),
        .i_src_port(i_src_port), .i_dst_port(i_dst_port),
        .i_udp_payload_length(i_udp_payload_length), .i_udp_checksum(i_udp_checksum),
        .i_ready(i_ready), .o_busy(o_busy), .o_error(o_error), .o_valid(o_valid),
        .o_data(o_data), .o_last(o_last), .o_last_word_data_valid(o_last_word_data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference IPv4 header words for a given packet ID.
    function automatic logic [7:0][63:0] model4(input vec_t v, input logic [15:0] id);
        logic [7:0][63:0] w;
        logic [15:0] tl, ul, cs;
        int s;
        tl = v.payload + 16'd28;
        ul = v.payload + 16'd8;
        s = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011
          + 32'(v.src4[31:16]) + 32'(v.src4[15:0]) + 32'(v.dst4[31:16]) + 32'(v.dst4[15:0]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        w    = '0;
        w[0] = {DMAC, SMAC[47:32]};
        w[1] = {SMAC[31:0], 16'h0800, 16'h4500};
        w[2] = {tl, id, 16'h4000, 8'h40, 8'h11};
        w[3] = {cs, v.src4, v.dst4[31:16]};
        w[4] = {v.dst4[15:0], SPORT, DPORT, ul};
        w[5] = {v.ucsum, 48'd0};
        return w;
    endfunction

    task automatic drive_start(input vec_t v);
        @(negedge clk);
        i_ipv6 = v.ipv6; i_src_ip4 = v.src4; i_dst_ip4 = v.dst4;
        i_src_ip6 = v.src6; i_dst_ip6 = v.dst6;
        i_udp_payload_length = v.payload; i_udp_checksum = v.ucsum;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Send one header and check every presented word; optional stall/abort word.
    task automatic run_packet(input vec_t v, input logic [7:0][63:0] exp,
                              input int stall_word, input int clear_word, input string nm);
        int lat, idx, stall, hs, cyc, nw;
        logic done;
        nw = v.ipv6 ? 8 : 6;
        i_ready = 1'b1;
        drive_start(v);
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), v.ipv6 ? 64'd1 : 64'd7);
        idx = 0; stall = 3; hs = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            chk($sformatf("%s w%0d valid", nm, idx), 64'(o_valid), 64'd1);
            if (!o_valid) begin
                done = 1'b1;
            end else if (clear_word == idx) begin
                i_clear = 1'b1;
                @(posedge clk);
                @(negedge clk);
                i_clear = 1'b0;
                chk({nm, " clear valid"}, 64'(o_valid), 64'd0);
                chk({nm, " clear busy"}, 64'(o_busy), 64'd0);
                done = 1'b1;
            end else begin
                chk($sformatf("%s w%0d data", nm, idx), o_data, exp[idx]);
                chk($sformatf("%s w%0d last", nm, idx), 64'(o_last), (idx == nw - 1) ? 64'd1 : 64'd0);
                chk($sformatf("%s w%0d mask", nm, idx), 64'(o_last_word_data_valid),
                    (idx != nw - 1) ? 64'hFF : (v.ipv6 ? 64'hFC : 64'hC0));
                if (idx == stall_word && stall > 0) begin
                    i_ready = 1'b0;
                    stall--;
                end else begin
                    i_ready = 1'b1;
                    hs++;
                    idx++;
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (idx == nw) done = 1'b1;
            end
        end
        i_ready = 1'b1;
        if (clear_word < 0) begin
            chk({nm, " handshakes"}, 64'(hs), 64'(nw));
            chk({nm, " end valid"}, 64'(o_valid), 64'd0);
            chk({nm, " end busy"}, 64'(o_busy), 64'd0);
        end
    endtask

    // A start whose length overflows must only pulse o_error.
    task automatic run_overflow(input vec_t v, input string nm);
        int seen;
        drive_start(v);
        chk({nm, " error pulse"}, 64'(o_error), 64'd1);
        chk({nm, " busy"}, 64'(o_busy), 64'd0);
        @(negedge clk);
        chk({nm, " error drop"}, 64'(o_error), 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_valid || o_busy) seen++;
            @(negedge clk);
        end
        chk({nm, " no activity"}, 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t v;
        int seen;
        i_areset = 1'b1; i_clear = 1'b0; i_start = 1'b0; i_ipv6 = 1'b0; i_ready = 1'b1;
        i_dst_mac = DMAC; i_src_mac = SMAC; i_src_port = SPORT; i_dst_port = DPORT;
        i_src_ip4 = 32'd0; i_dst_ip4 = 32'd0; i_src_ip6 = 128'd0; i_dst_ip6 = 128'd0;
        i_udp_payload_length = 16'd0; i_udp_checksum = 16'd0;

        tbl[0] = '{ipv6: 1'b0, src4: 32'hC0A8_0001, dst4: 32'hC0A8_00C7, src6: 128'd0, dst6: 128'd0,
                   payload: 16'd87, ucsum: 16'h5A5A,
                   w: {64'd0, 64'd0,
                       64'h5A5A_0000_0000_0000, 64'h00C7_007B_116C_005F,
                       64'hB861_C0A8_0001_C0A8, 64'h0073_0000_4000_4011,
                       64'h8899_AABB_0800_4500, 64'h0011_2233_4455_6677}};
        tbl[1] = '{ipv6: 1'b1, src4: 32'd0, dst4: 32'd0, src6: 128'd1, dst6: 128'd2,
                   payload: 16'd40, ucsum: 16'hABCD,
                   w: {64'h116C_0030_ABCD_0000, 64'h0000_0000_0002_007B,
                       64'h0000_0000_0000_0000, 64'h0000_0000_0001_0000,
                       64'h0000_0000_0000_0000, 64'h0000_0030_1140_0000,
                       64'h8899_AABB_86DD_6000, 64'h0011_2233_4455_6677}};
        tbl[2] = '{ipv6: 1'b0, src4: 32'h0A00_0001, dst4: 32'h0A00_0002, src6: 128'd0, dst6: 128'd0,
                   payload: 16'd65507, ucsum: 16'h1357,
                   w: {64'd0, 64'd0,
                       64'h1357_0000_0000_0000, 64'h0002_007B_116C_FFEB,
                       64'h26EA_0A00_0001_0A00, 64'hFFFF_0001_4000_4011,
                       64'h8899_AABB_0800_4500, 64'h0011_2233_4455_6677}};

        repeat (3) @(negedge clk);
        chk("reset valid", 64'(o_valid), 64'd0);
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset error", 64'(o_error), 64'd0);
        chk("reset data", o_data, 64'd0);
        chk("reset last", 64'(o_last), 64'd0);
        chk("reset mask", 64'(o_last_word_data_valid), 64'd0);
        i_areset = 1'b0;

        // Reset during the checksum phase.
        drive_start(tbl[0]);
        @(negedge clk);
        chk("csum busy", 64'(o_busy), 64'd1);
        i_areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_areset = 1'b0;
        chk("areset busy", 64'(o_busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_valid) seen++;
            @(negedge clk);
        end
        chk("areset no valid", 64'(seen), 64'd0);

        // Table: IPv4 ID 0, IPv6 (ID untouched), IPv4 max payload with ID 1.
        for (int k = 0; k < 3; k++) begin
            run_packet(tbl[k], tbl[k].w, -1, -1, $sformatf("vec%0d", k));
        end

        v = tbl[0]; v.payload = 16'd65508;
        run_overflow(v, "ovf4");
        v = tbl[1]; v.payload = 16'd65528;
        run_overflow(v, "ovf6");

        run_packet(tbl[0], model4(tbl[0], 16'd2), 3, -1, "bp");
        run_packet(tbl[0], model4(tbl[0], 16'd3), -1, 2, "clr");
        run_packet(tbl[0], model4(tbl[0], 16'd3), -1, -1, "after_clr");

        @(negedge clk);
        force dut.id_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.id_q;
        run_packet(tbl[2], model4(tbl[2], 16'hFFFF), -1, -1, "id_ffff");
        run_packet(tbl[0], model4(tbl[0], 16'h0000), -1, -1, "id_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
